mul_scheduler: RTL and testbench
================================

MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the multiplier.
REQ-002 Parameter DATA_W, default 16, operand/result width, Q8.8 signed.
REQ-003 Parameter TIMEOUT_CYC, default 64, max cycles waited for mul_done.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  N_REQ  per-requester operation request.
REQ-007 req_a, req_b  in  N_REQ*DATA_W  per-requester signed multiplicand/multiplier, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  out  N_REQ  per-requester accept; at most one bit high.
REQ-009 rsp_valid  out  N_REQ  per-requester result valid; at most one bit high.
REQ-010 rsp_ready  in  N_REQ  per-requester result consume.
REQ-011 rsp_result  out  DATA_W  shared rounded Q8.8 product.
REQ-012 rsp_ovf, rsp_err  out  1 each  overflow flag from multiplier; timeout error.
REQ-013 mul_start  out  1  one-cycle start pulse to shared multiplier.
REQ-014 mul_a, mul_b  out  DATA_W each  registered operands to multiplier.
REQ-015 mul_done, mul_ovf  in  1 each  multiplier completion and overflow.
REQ-016 mul_result  in  DATA_W  multiplier rounded result, valid with mul_done.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: req_ready SHALL be high combinationally only for the round-robin winner among req_valid; no bit when none valid.
REQ-020 Round-robin: search starts at pointer ptr; after a grant ptr SHALL become (winner+1) mod N_REQ.
REQ-021 Handshake req_valid&req_ready SHALL latch operands into mul_a/mul_b, latch grant index, go to ISSUE.
REQ-022 ISSUE: mul_start SHALL be high exactly one cycle, then WAIT; timeout counter cleared.
REQ-023 WAIT: mul_done SHALL latch mul_result to rsp_result and mul_ovf to rsp_ovf, rsp_err=0, go to RESP.
REQ-024 WAIT: counter reaching TIMEOUT_CYC without mul_done SHALL give rsp_result=0, rsp_ovf=0, rsp_err=1, go to RESP.
REQ-025 mul_done outside WAIT SHALL be ignored; mul_done on timeout cycle SHALL take priority over timeout.
REQ-026 RESP: rsp_valid[grant] SHALL stay high, rsp_* stable, until rsp_ready[grant]; then IDLE next cycle.
REQ-027 No new request SHALL be accepted in ISSUE, WAIT or RESP; req_ready all zero there.
REQ-028 Latency: accept edge T, mul_start in cycle T+1, mul_done seen at cycle K, rsp_valid from cycle K+1.
REQ-029 Back-to-back: next accept earliest the cycle after RESP->IDLE transition.

Reset
REQ-030 reset low SHALL asynchronously force IDLE, ptr=0, counter=0, mul_start=0, mul_a=mul_b=0, rsp_result=0, rsp_ovf=rsp_err=0, rsp_valid=0, busy=0.
REQ-031 Reset mid-operation SHALL abandon the in-flight operation with no response; a later stale mul_done SHALL be ignored.

Structure
REQ-032 Package mul_sched_pkg SHALL hold the FSM state enum and default constants N_REQ, DATA_W, TIMEOUT_CYC.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector, ptr; output one-hot grant, index).

Verification
REQ-034 Req0 a=0x0180, b=0x0200, mul returns 0x0300 after 5 cycles -> rsp_valid[0], rsp_result=0x0300, ovf=0, err=0, latency per REQ-028.
REQ-035 All four req_valid held, mul_done after 3 cycles, rsp_ready immediate -> grant order 0,1,2,3,0.
REQ-036 Req2 a=0x7F00, b=0x0200, mul_ovf=1 -> rsp_valid[2], rsp_ovf=1.
REQ-037 mul_done never asserted -> exactly 64 cycles in WAIT, then rsp_err=1, rsp_result=0x0000.
REQ-038 reset low during WAIT, mul_done pulsed after release -> no rsp_valid, busy=0, ptr=0.
REQ-039 rsp_ready withheld 10 cycles -> rsp_valid and rsp_result stable, req_ready all zero throughout.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types and default sizing for the multiplier scheduler.
package mul_sched_pkg;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N_REQ-1:0][IDX_W-1:0] w_pos;

    always_comb begin
        w_pos   = '0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos[k] = IDX_W'((int'(i_ptr) + k) % N_REQ);
            if (!o_any && i_req[w_pos[k]]) begin
                o_grant[w_pos[k]] = 1'b1;
                o_idx             = w_pos[k];
                o_any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one external multiplier among N_REQ requesters: arbitrate, issue,
// wait for completion or timeout, then hold the response until consumed.
module mul_scheduler
    import mul_sched_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*DATA_W-1:0]  i_req_a,
    input  logic [N_REQ*DATA_W-1:0]  i_req_b,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic [N_REQ-1:0]         o_rsp_valid,
    input  logic [N_REQ-1:0]         i_rsp_ready,
    output logic [DATA_W-1:0]        o_rsp_result,
    output logic                     o_rsp_ovf,
    output logic                     o_rsp_err,
    output logic                     o_mul_start,
    output logic [DATA_W-1:0]        o_mul_a,
    output logic [DATA_W-1:0]        o_mul_b,
    input  logic                     i_mul_done,
    input  logic                     i_mul_ovf,
    input  logic [DATA_W-1:0]        i_mul_result,
    output logic                     o_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_gidx;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_mul_a;
    logic [DATA_W-1:0]   r_mul_b;
    logic [DATA_W-1:0]   r_rsp_result;
    logic                r_rsp_ovf;
    logic                r_rsp_err;

    logic [N_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]    w_widx;
    logic                w_any;
    logic                w_accept;
    logic                w_rsp_hs;
    logic                w_timeout;
    logic [IDX_W-1:0]    w_next_ptr;
    logic [N_REQ-1:0]    w_gsel;
    logic [DATA_W-1:0]   w_op_a;
    logic [DATA_W-1:0]   w_op_b;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_widx),
        .o_any   (w_any)
    );

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_widx == IDX_W'(i)) begin
                w_op_a = i_req_a[i*DATA_W +: DATA_W];
                w_op_b = i_req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_accept   = (r_state == ST_IDLE) && w_any;
    assign w_gsel     = N_REQ'(1) << r_gidx;
    assign w_rsp_hs   = |(o_rsp_valid & i_rsp_ready);
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_next_ptr = (w_widx == IDX_W'(N_REQ - 1)) ? '0 : w_widx + 1'b1;

    assign o_req_ready  = (r_state == ST_IDLE) ? w_grant : '0;
    assign o_rsp_valid  = (r_state == ST_RESP) ? w_gsel  : '0;
    assign o_mul_start  = (r_state == ST_ISSUE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_mul_a      = r_mul_a;
    assign o_mul_b      = r_mul_b;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_ovf    = r_rsp_ovf;
    assign o_rsp_err    = r_rsp_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_gidx       <= '0;
            r_cnt        <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_rsp_result <= '0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mul_a <= w_op_a;
                        r_mul_b <= w_op_b;
                        r_gidx  <= w_widx;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // completion wins over a timeout landing on the same cycle
                    if (i_mul_done) begin
                        r_rsp_result <= i_mul_result;
                        r_rsp_ovf    <= i_mul_ovf;
                        r_rsp_err    <= 1'b0;
                        r_state      <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_result <= '0;
                        r_rsp_ovf    <= 1'b0;
                        r_rsp_err    <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_hs) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_scheduler.sv
// Scoreboarded bench: a behavioural multiplier answers mul_start, expected
// responses are queued at accept time and compared when the DUT responds.
module tb_mul_scheduler;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     o_req_ready, o_rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [W-1:0]     o_rsp_result, o_mul_a, o_mul_b;
    logic             o_rsp_ovf, o_rsp_err, o_mul_start, o_busy;
    logic             m_done, f_done, m_ovf, mul_done;
    logic [W-1:0]     m_res;

    assign mul_done = m_done | f_done;

    always #5 clk = ~clk;

    mul_scheduler #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_req_ready  (o_req_ready),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (o_rsp_result),
        .o_rsp_ovf    (o_rsp_ovf),
        .o_rsp_err    (o_rsp_err),
        .o_mul_start  (o_mul_start),
        .o_mul_a      (o_mul_a),
        .o_mul_b      (o_mul_b),
        .i_mul_done   (mul_done),
        .i_mul_ovf    (m_ovf),
        .i_mul_result (m_res),
        .o_busy       (o_busy)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] res;
        logic         ovf;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, m_ptr = 0, mock_delay = 3, n_rsp = 0;
    int   acc_cyc = 0, start_cyc = 0, rspv_cyc = 0, hs_cyc = 0;
    bit   in_rsp = 1'b0;
    int   last_idx;
    logic [W-1:0] last_res;
    logic last_ovf, last_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    endtask

    // Q8.8 signed multiply, round half up, saturate with overflow flag
    function automatic logic [W:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [31:0] sa, sb_, p;
        sa = {{16{a[W-1]}}, a};
        sb_ = {{16{b[W-1]}}, b};
        p = (sa * sb_ + 32'sd128) >>> 8;
        if (p > 32'sd32767)  return {1'b1, 16'h7FFF};
        if (p < -32'sd32768) return {1'b1, 16'h8000};
        return {1'b0, p[W-1:0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic wait_acc(input int n0);
        for (int k = 0; k < 50; k++) begin
            if (grant_log.size() > n0) break;
            tick(1);
        end
        chk("acc_timeout", 32'(grant_log.size() > n0), 1);
    endtask

    task automatic wait_idle(input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            if (!o_busy && sb.size() == 0) break;
            tick(1);
        end
        chk("idle_timeout", 32'(k < bound), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // behavioural multiplier: result valid only with mul_done, junk otherwise
    initial begin : mock
        int           cnt;
        logic [W-1:0] ma, mb;
        logic [W:0]   q;
        cnt = 0; m_done = 0; m_ovf = 0; m_res = 0;
        forever begin
            @(posedge clk);
            #1;
            m_done = 1'b0;
            m_res  = W'($urandom);
            m_ovf  = 1'($urandom);
            if (!rst_n) cnt = 0;
            else if (o_mul_start) begin
                start_cyc = cyc;
                cnt = mock_delay;
                ma = o_mul_a;
                mb = o_mul_b;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    q = qmul(ma, mb);
                    m_res  = q[W-1:0];
                    m_ovf  = q[W];
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : acc_mon
        int w;
        exp_t e;
        logic [W:0] q;
        if (rst_n && |(o_req_ready & req_valid)) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            chk("rdy_onehot", 32'($onehot(o_req_ready)), 1);
            chk("grant", 32'(o_req_ready), 32'(1) << w);
            e.idx = w;
            if (mock_delay < 0) begin
                e.res = '0; e.ovf = 1'b0; e.err = 1'b1;
            end else begin
                q = qmul(req_a[w*W +: W], req_b[w*W +: W]);
                e.res = q[W-1:0]; e.ovf = q[W]; e.err = 1'b0;
            end
            sb.push_back(e);
            grant_log.push_back(w);
            m_ptr   = (w + 1) % N;
            acc_cyc = cyc;
        end
    end

    always @(negedge clk) begin : rsp_mon
        exp_t e;
        if (rst_n && |o_rsp_valid) begin
            if (!in_rsp) begin
                in_rsp   = 1'b1;
                rspv_cyc = cyc;
                chk("rsp_onehot", 32'($onehot(o_rsp_valid)), 1);
            end
            if (|(o_rsp_valid & rsp_ready)) begin
                in_rsp = 1'b0;
                hs_cyc = cyc;
                n_rsp++;
                last_res = o_rsp_result; last_ovf = o_rsp_ovf; last_err = o_rsp_err;
                last_idx = 0;
                for (int k = 0; k < N; k++) if (o_rsp_valid[k]) last_idx = k;
                chk("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_idx", 32'(o_rsp_valid), 32'(1) << e.idx);
                    chk("rsp_result", 32'(o_rsp_result), 32'(e.res));
                    chk("rsp_ovf", 32'(o_rsp_ovf), 32'(e.ovf));
                    chk("rsp_err", 32'(o_rsp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, nr;
        rst_n = 0; req_valid = '0; req_a = '0; req_b = '0;
        rsp_ready = '0; f_done = 0; mock_delay = 3;
        tick(3);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_start", 32'(o_mul_start), 0);
        chk("rst_mul_a", 32'(o_mul_a), 0);
        chk("rst_mul_b", 32'(o_mul_b), 0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
        chk("rst_rsp_res", 32'(o_rsp_result), 0);
        chk("rst_rsp_flags", 32'({o_rsp_ovf, o_rsp_err}), 0);
        chk("rst_req_ready", 32'(o_req_ready), 0);
        rst_n = 1;
        tick(1);

        // all four held: strict rotation starting from pointer 0
        for (int i = 0; i < N; i++) set_req(i, W'(16'h0100 * (i + 1)), W'(16'h0080 + i));
        rsp_ready = '1;
        n0 = grant_log.size();
        req_valid = '1;
        for (int k = 0; k < 200 && grant_log.size() < n0 + 5; k++) tick(1);
        req_valid = '0;
        for (int k = 0; k < 5; k++)
            chk("grant_order", (n0 + k < grant_log.size()) ? grant_log[n0 + k] : -1, k % N);
        wait_idle(100);

        // single op with latency measurement
        mock_delay = 5;
        set_req(0, 16'h0180, 16'h0200);
        n0 = grant_log.size();
        req_valid = 4'b0001;
        wait_acc(n0);
        req_valid = '0;
        wait_idle(100);
        chk("lat_start", start_cyc - acc_cyc, 1);
        chk("lat_rsp", rspv_cyc - start_cyc, 6);
        chk("t1_idx", last_idx, 0);
        chk("t1_res", 32'(last_res), 32'h0300);
        chk("t1_flags", 32'({last_ovf, last_err}), 0);

        // overflow passthrough from requester 2
        mock_delay = 4;
        set_req(2, 16'h7F00, 16'h0200);
        n0 = grant_log.size();
        req_valid = 4'b0100;
        wait_acc(n0);
        req_valid = '0;
        wait_idle(100);
        chk("ovf_idx", last_idx, 2);
        chk("ovf_flag", 32'(last_ovf), 1);

        // multiplier never answers: timeout after exactly TO wait cycles
        mock_delay = -1;
        set_req(1, 16'h0300, 16'h0100);
        n0 = grant_log.size();
        req_valid = 4'b0010;
        wait_acc(n0);
        req_valid = '0;
        wait_idle(300);
        chk("to_wait_cycles", rspv_cyc - start_cyc - 1, TO);
        chk("to_err", 32'(last_err), 1);
        chk("to_res", 32'(last_res), 0);
        chk("to_ovf", 32'(last_ovf), 0);

        // response back-pressure, then back-to-back accept
        mock_delay = 2;
        rsp_ready = '0;
        set_req(3, 16'h0100, 16'h0250);
        n0 = grant_log.size();
        req_valid = 4'b1000;
        wait_acc(n0);
        req_valid = 4'b0001;
        for (int k = 0; k < 50 && o_rsp_valid == '0; k++) tick(1);
        for (int k = 0; k < 10; k++) begin
            chk("hold_valid", 32'(o_rsp_valid), 32'b1000);
            chk("hold_res", 32'(o_rsp_result), 32'h0250);
            chk("hold_ready", 32'(o_req_ready), 0);
            tick(1);
        end
        rsp_ready = '1;
        n0 = grant_log.size();
        wait_acc(n0);
        req_valid = '0;
        chk("b2b_accept", acc_cyc - hs_cyc, 1);
        wait_idle(100);

        // reset while waiting: abandon op, ignore stale done, pointer back to 0
        mock_delay = -1;
        set_req(2, 16'h0200, 16'h0200);
        n0 = grant_log.size();
        req_valid = 4'b0100;
        wait_acc(n0);
        req_valid = '0;
        tick(4);
        rst_n = 0;
        #1;
        chk("mid_rst_busy", 32'(o_busy), 0);
        chk("mid_rst_valid", 32'(o_rsp_valid), 0);
        chk("mid_rst_mul_a", 32'(o_mul_a), 0);
        chk("mid_rst_res", 32'(o_rsp_result), 0);
        sb.delete();
        m_ptr = 0;
        in_rsp = 1'b0;
        tick(2);
        rst_n = 1;
        tick(1);
        nr = n_rsp;
        f_done = 1;
        tick(1);
        f_done = 0;
        tick(5);
        chk("stale_no_rsp", n_rsp - nr, 0);
        chk("stale_busy", 32'(o_busy), 0);
        mock_delay = 2;
        n0 = grant_log.size();
        req_valid = '1;
        wait_acc(n0);
        req_valid = '0;
        chk("ptr_after_rst", (grant_log.size() > n0) ? grant_log[n0] : -1, 0);
        wait_idle(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
